// File: rtl/fetch_decode.sv
// Fetch/decode front end: fetches 16-bit words from a 32-word imem and presents decoded fields to execute.
// Optional build macro FD_JUMP_EN: when defined, opcode 4'hD loads PC from instr[4:0] on completion.
module fetch_decode (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic        imem_req,
  output logic [4:0]  imem_addr,
  input  logic        imem_ack,
  input  logic [15:0] imem_rdata,
  output logic        dec_valid,
  input  logic        exec_ready,
  output logic [3:0]  opcode,
  output logic        am,
  output logic [2:0]  rd,
  output logic [2:0]  rs1,
  output logic [2:0]  rs2,
  output logic [4:0]  mem_addr,
  output logic [4:0]  instr_mem_addr,
  output logic        halted
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_WAIT  = 3'd2,
    S_ISSUE = 3'd3,
    S_HALT  = 3'd4
  } state_t;

  localparam logic [3:0] OP_HALT = 4'hF;
  localparam logic [3:0] OP_JUMP = 4'hD;

`ifdef FD_JUMP_EN
  localparam logic JUMP_EN = 1'b1;
`else
  localparam logic JUMP_EN = 1'b0;
`endif

  state_t      state_q, state_d;
  logic [4:0]  pc_q, pc_d;
  logic [15:0] ir_q, ir_d;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    imem_req  = 1'b0;
    dec_valid = 1'b0;
    halted    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          pc_d    = '0;
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        imem_req = 1'b1;
        state_d  = S_WAIT;
      end
      S_WAIT: begin
        if (imem_ack) begin
          ir_d    = imem_rdata;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        dec_valid = 1'b1;
        if (exec_ready) begin
          if (ir_q[15:12] == OP_HALT) begin
            state_d = S_HALT;
          end else begin
            state_d = S_FETCH;
            // PC stays pointing at the issued word until the transfer completes
            if (JUMP_EN && (ir_q[15:12] == OP_JUMP)) pc_d = ir_q[4:0];
            else                                     pc_d = pc_q + 5'd1;
          end
        end
      end
      S_HALT: begin
        halted = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign imem_addr      = pc_q;
  assign instr_mem_addr = pc_q;
  assign opcode         = ir_q[15:12];
  assign am             = ir_q[11];
  assign rd             = ir_q[10:8];
  assign rs1            = ir_q[7:5];
  assign rs2            = ir_q[4:2];
  assign mem_addr       = ir_q[4:0];

endmodule
